cmd_sched: RTL and testbench

CMD_SCHED -- requirements
Module: cmd_sched

---
 rtl/cmd_sched_if.sv | 42 ++++
 rtl/cmd_sched.sv | 165 ++++++++++++++++
 tb/tb_cmd_sched.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_sched_if.sv
// ============================================================================
// cmd_sched_if : command-write, registry-memory and pulse-engine signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface cmd_sched_if #(
  parameter int AW = 8,
  parameter int DW = 338
);
  logic          WR;
  logic [DW-1:0] DATA_IN;
  logic          FLUSH;
  logic [63:0]   TIME_NOW;
  logic          CMD_READY;
  logic [DW-1:0] mem_q;
  logic          mem_wren;
  logic [AW-1:0] mem_wraddress;
  logic [DW-1:0] mem_data;
  logic          mem_rden;
  logic [AW-1:0] mem_rdaddress;
  logic          CMD_VALID;
  logic [DW-1:0] CMD_OUT;
  logic          FULL;
  logic [AW:0]   USED;
  logic          ERR_OVF;
  logic          ERR_LATE;

  modport slave (
    input  WR, DATA_IN, FLUSH, TIME_NOW, CMD_READY, mem_q,
    output mem_wren, mem_wraddress, mem_data, mem_rden, mem_rdaddress,
    output CMD_VALID, CMD_OUT, FULL, USED, ERR_OVF, ERR_LATE
  );

  modport master (
    output WR, DATA_IN, FLUSH, TIME_NOW, CMD_READY, mem_q,
    input  mem_wren, mem_wraddress, mem_data, mem_rden, mem_rdaddress,
    input  CMD_VALID, CMD_OUT, FULL, USED, ERR_OVF, ERR_LATE
  );
endinterface

`default_nettype wire

// File: rtl/cmd_sched.sv
// ============================================================================
// cmd_sched : in-order timed command scheduler over an external registry RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module cmd_sched #(
  parameter int AW     = 8,
  parameter int DW     = 338,
  parameter int RD_LAT = 2
) (
  input  wire logic  CLK,
  input  wire logic  rst_n,
  cmd_sched_if.slave bus
);

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [AW+1:0] C_FULL = {2'b01, {AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    ARMED   = 3'd3,
    ISSUE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used_q, used_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
  logic [DW-1:0] entry_q, entry_d;
  logic          first_q, first_d;
  logic          wren_q;
  logic [AW-1:0] wraddr_q;
  logic [DW-1:0] wdata_q;
  logic          err_ovf_q;
  logic          err_late_q, err_late_d;

  logic          armed;
  logic [AW+1:0] occupancy;
  logic          full;
  logic          wr_acc;
  logic [63:0]   entry_ts;
  logic          time_ok;
  logic          late_now;
  logic          cmd_valid;
  logic          hs;

  // The slot being read, waited on or presented still counts as occupied.
  assign armed     = (state_q == RD_WAIT) || (state_q == ARMED) || (state_q == ISSUE);
  assign occupancy = {1'b0, used_q} + {{(AW+1){1'b0}}, wren_q} + {{(AW+1){1'b0}}, armed};
  assign full      = (occupancy == C_FULL);
  assign wr_acc    = bus.WR & ~full & ~bus.FLUSH;

  assign entry_ts  = entry_q[209:146];
  assign time_ok   = (bus.TIME_NOW >= entry_ts);
  assign late_now  = first_q & (entry_ts < bus.TIME_NOW);
  // Valid rises in the very cycle the start time is reached, not one later.
  assign cmd_valid = (state_q == ISSUE) || ((state_q == ARMED) && !late_now && time_ok);
  assign hs        = cmd_valid & bus.CMD_READY;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    lat_cnt_d  = lat_cnt_q;
    entry_d    = entry_q;
    first_d    = 1'b0;
    err_late_d = 1'b0;
    used_d     = used_q + {{AW{1'b0}}, wren_q};
    case (state_q)
      IDLE: begin
        if (used_q != '0) state_d = RD_REQ;
      end
      RD_REQ: begin
        used_d    = used_d - (AW+1)'(1);
        lat_cnt_d = CW'(1);
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_cnt_q == CW'(RD_LAT)) begin
          entry_d  = bus.mem_q;
          rd_ptr_d = rd_ptr_q + AW'(1);
          first_d  = 1'b1;
          state_d  = ARMED;
        end else begin
          lat_cnt_d = lat_cnt_q + CW'(1);
        end
      end
      ARMED: begin
        if (late_now) begin
          err_late_d = 1'b1;
          state_d    = IDLE;
        end else if (hs) begin
          state_d = IDLE;
        end else if (time_ok) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      lat_cnt_q  <= '0;
      entry_q    <= '0;
      first_q    <= 1'b0;
      wren_q     <= 1'b0;
      wraddr_q   <= '0;
      wdata_q    <= '0;
      err_ovf_q  <= 1'b0;
      err_late_q <= 1'b0;
    end else if (bus.FLUSH) begin
      // Zeroing USED here also discards the commit of a write already on the port.
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      lat_cnt_q  <= '0;
      first_q    <= 1'b0;
      wren_q     <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_late_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      lat_cnt_q  <= lat_cnt_d;
      entry_q    <= entry_d;
      first_q    <= first_d;
      wren_q     <= wr_acc;
      err_ovf_q  <= bus.WR & full;
      err_late_q <= err_late_d;
      if (wr_acc) begin
        wraddr_q <= wr_ptr_q;
        wdata_q  <= bus.DATA_IN;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
    end
  end

  assign bus.mem_wren      = wren_q;
  assign bus.mem_wraddress = wraddr_q;
  assign bus.mem_data      = wdata_q;
  assign bus.mem_rden      = (state_q == RD_REQ);
  assign bus.mem_rdaddress = rd_ptr_q;
  assign bus.CMD_VALID     = cmd_valid;
  assign bus.CMD_OUT       = entry_q;
  assign bus.FULL          = full;
  assign bus.USED          = used_q;
  assign bus.ERR_OVF       = err_ovf_q;
  assign bus.ERR_LATE      = err_late_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_sched.sv
// ============================================================================
// tb_cmd_sched : scoreboard bench for cmd_sched with a behavioural registry RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmd_sched;

  localparam int AW     = 8;
  localparam int DW     = 338;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;
  // Frozen time with a nonzero upper word so a truncated compare is exposed.
  localparam logic [63:0] T_FRZ  = 64'h0000_0001_0000_0010;
  localparam logic [63:0] T_LATE = 64'h0000_0000_FFFF_FFF0;

  typedef struct {
    logic [DW-1:0] data;
    bit            late;
  } cmd_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;

  cmd_sched_if #(.AW(AW), .DW(DW)) bus();

  cmd_sched #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Registry RAM model: RD_LAT-cycle registered read.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge CLK) begin
    if (bus.mem_wren) mem[bus.mem_wraddress] <= bus.mem_data;
    if (bus.mem_rden) rd_pipe[0] <= mem[bus.mem_rdaddress];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_q = rd_pipe[RD_LAT-1];

  cmd_t          exp_cmd[$];
  wr_t           exp_wr[$];
  int            exp_ovf  = 0;
  int            late_exp = 0;
  int            late_seen = 0;
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] wr_addr = '0;
  bit            time_run = 1'b0;
  bit            rand_ready = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT presents one.
  cmd_t mc;
  wr_t  mw;
  initial forever begin
    @(negedge CLK);
    if (rst_n) begin
      if (bus.mem_wren) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr=%0d required=none", bus.mem_wraddress);
        end else begin
          mw = exp_wr.pop_front();
          if (bus.mem_wraddress !== mw.addr || bus.mem_data !== mw.data) begin
            errors++;
            $display("FAIL wr_port addr=%0d required=%0d data=%0h required=%0h",
                     bus.mem_wraddress, mw.addr, bus.mem_data, mw.data);
          end
        end
      end
      if (bus.CMD_VALID && bus.CMD_READY) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected cmd=%0h required=none", bus.CMD_OUT);
        end else begin
          mc = exp_cmd.pop_front();
          if (mc.late || bus.CMD_OUT !== mc.data) begin
            errors++;
            $display("FAIL issue cmd=%0h late_expected=%0d required=%0h", bus.CMD_OUT, mc.late, mc.data);
          end
        end
      end
      if (bus.ERR_LATE) begin
        checks++;
        late_seen++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL late_unexpected actual=1 required=0");
        end else begin
          mc = exp_cmd.pop_front();
          if (!mc.late) begin
            errors++;
            $display("FAIL late_drop dropped=%0h required=issue", mc.data);
          end
        end
      end
      if (bus.ERR_OVF) begin
        checks++;
        if (exp_ovf == 0) begin
          errors++;
          $display("FAIL ovf_unexpected actual=1 required=0");
        end else begin
          exp_ovf--;
        end
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (rand_ready) bus.CMD_READY = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (time_run) bus.TIME_NOW = bus.TIME_NOW + 64'd1;
    #1;
  endtask

  function automatic logic [DW-1:0] mk_cmd(logic [63:0] ts);
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = 1'($urandom);
    d[209:146] = ts;
    return d;
  endfunction

  task automatic do_write(logic [DW-1:0] d, bit late);
    cmd_t c;
    wr_t  w;
    c.data = d;
    c.late = late;
    w.addr = wr_addr;
    w.data = d;
    exp_cmd.push_back(c);
    exp_wr.push_back(w);
    wr_addr = wr_addr + AW'(1);
    if (late) late_exp++;
    bus.WR      = 1'b1;
    bus.DATA_IN = d;
    tick();
    bus.WR = 1'b0;
  endtask

  task automatic clear_model();
    exp_cmd.delete();
    exp_wr.delete();
    exp_ovf = 0;
    wr_addr = '0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_cmd.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_cmd.size()), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_wren", bus.mem_wren, 0);
    chk("rst_mem_rden", bus.mem_rden, 0);
    chk("rst_cmd_valid", bus.CMD_VALID, 0);
    chk("rst_err_ovf", bus.ERR_OVF, 0);
    chk("rst_err_late", bus.ERR_LATE, 0);
    chk("rst_full", bus.FULL, 0);
    chk("rst_used", bus.USED, 0);
    chk("rst_wraddr", bus.mem_wraddress, 0);
    chk("rst_rdaddr", bus.mem_rdaddress, 0);
    chk("rst_cmd_out_zero", 64'(bus.CMD_OUT != '0), 0);
    chk("rst_mem_data_zero", 64'(bus.mem_data != '0), 0);
  endtask

  logic [DW-1:0] d;
  int            found;
  int            nvalid;
  int            n;
  bit            late;

  initial begin
    bus.WR        = 1'b0;
    bus.DATA_IN   = '0;
    bus.FLUSH     = 1'b0;
    bus.TIME_NOW  = 64'd100;
    bus.CMD_READY = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Single on-time command waiting for TIME_NOW to reach its start.
    bus.TIME_NOW  = 64'd100;
    time_run      = 1'b1;
    bus.CMD_READY = 1'b1;
    do_write(mk_cmd(64'd200), 1'b0);
    chk("wr_latency_wren", bus.mem_wren, 1);
    chk("wr_latency_addr", bus.mem_wraddress, 0);
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (bus.CMD_VALID) found = 1;
      else tick();
    end
    chk("valid_seen", 64'(found), 1);
    chk("valid_rise_time", bus.TIME_NOW, 200);
    tick();
    chk("valid_drop_after_hs", bus.CMD_VALID, 0);
    chk("used_back_to_zero", bus.USED, 0);

    // Late command is dropped, the one behind it still issues.
    do_write(mk_cmd(64'd50), 1'b1);
    do_write(mk_cmd(bus.TIME_NOW + 64'd40), 1'b0);
    wait_drain("late_then_next_drain", 300);
    chk("late_pulse_count", 64'(late_seen), 1);

    // Fill to FULL with the first entry armed and the engine stalled.
    time_run      = 1'b0;
    bus.TIME_NOW  = T_FRZ;
    bus.CMD_READY = 1'b0;
    do_write(mk_cmd(T_FRZ), 1'b0);
    repeat (10) tick();
    chk("fill_first_presented", bus.CMD_VALID, 1);
    for (int i = 1; i < DEPTH - 1; i++) do_write(mk_cmd(T_FRZ), 1'b0);
    chk("fill_not_full_at_255", bus.FULL, 0);
    do_write(mk_cmd(T_FRZ), 1'b0);
    chk("fill_full_at_256", bus.FULL, 1);
    exp_ovf++;
    bus.WR      = 1'b1;
    bus.DATA_IN = mk_cmd(T_FRZ);
    tick();
    bus.WR = 1'b0;
    chk("ovf_pulse", bus.ERR_OVF, 1);
    chk("ovf_no_wren", bus.mem_wren, 0);
    chk("ovf_used", bus.USED, DEPTH - 1);
    bus.CMD_READY = 1'b1;
    wait_drain("fill_drain", 4000);

    // Random stream with stalls and wrapping pointers.
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      n = 0;
      while (exp_cmd.size() >= 200 && n < 3000) begin
        tick();
        n++;
      end
      if (n >= 3000) chk("backpressure_timeout", 1, 0);
      late = ($urandom_range(0, 4) == 0);
      do_write(mk_cmd(late ? T_LATE : T_FRZ), late);
    end
    wait_drain("random_drain", 5000);
    rand_ready = 1'b0;
    tick();

    // FLUSH while presenting a command with five more queued.
    bus.CMD_READY = 1'b0;
    for (int i = 0; i < 6; i++) do_write(mk_cmd(T_FRZ), 1'b0);
    repeat (20) tick();
    chk("flush_pre_valid", bus.CMD_VALID, 1);
    chk("flush_pre_used", bus.USED, 5);
    clear_model();
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    chk("flush_valid", bus.CMD_VALID, 0);
    chk("flush_used", bus.USED, 0);
    chk("flush_full", bus.FULL, 0);
    do_write(mk_cmd(T_FRZ), 1'b0);
    chk("flush_next_addr", bus.mem_wraddress, 0);
    bus.CMD_READY = 1'b1;
    wait_drain("flush_drain", 100);

    // Reset while ARMED abandons the entry.
    bus.CMD_READY = 1'b0;
    do_write(mk_cmd(T_FRZ + 64'd1000), 1'b0);
    repeat (15) tick();
    chk("armed_waiting_valid", bus.CMD_VALID, 0);
    rst_n = 1'b0;
    clear_model();
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    bus.CMD_READY = 1'b1;
    bus.TIME_NOW  = T_FRZ + 64'd2000;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.CMD_VALID) nvalid++;
    end
    chk("no_valid_after_reset", 64'(nvalid), 0);

    chk("late_total", 64'(late_seen), 64'(late_exp));
    chk("ovf_all_seen", 64'(exp_ovf), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
